// File: rtl/rename_alloc_ctrl.sv
// rename_alloc_ctrl: rename-stage sequencer for a 4-way dispatch bundle.
// Holds one bundle and computes the per-way PR need. It dequeues every needed
// PR from the free list in a single cycle, then presents the renamed bundle
// downstream under valid/ready.
// Optional build macro: RENAME_ALLOC_CTRL_PERF_EN adds perf_pr_stall_cycles.
module rename_alloc_ctrl #(
  parameter int PR_W = 7
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_valid_by_way,
  input  logic [3:0]           in_regwrite_by_way,
  input  logic [3:0][4:0]      in_dest_AR_by_way,
  output logic [3:0]           dep_regwrite_by_way,
  input  logic [2:0]           fl_avail_count,
  input  logic [3:0][PR_W-1:0] fl_PR_by_idx,
  output logic [2:0]           fl_deq_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_valid_by_way,
  output logic [3:0]           out_regwrite_by_way,
  output logic [3:0][4:0]      out_dest_AR_by_way,
  output logic [3:0][PR_W-1:0] out_dest_PR_by_way
`ifdef RENAME_ALLOC_CTRL_PERF_EN
  ,
  output logic [15:0]          perf_pr_stall_cycles
`endif
);

  typedef enum logic [1:0] {EMPTY, WAIT_PR, FULL} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             need_q;
  logic [3:0]             valid_q;
  logic [3:0][4:0]        ar_q;
  logic [3:0][PR_W-1:0]   pr_q;

  logic [3:0]             need_in;
  logic [2:0]             need_cnt_in;
  logic [2:0]             need_cnt_q;
  logic                   accept;
  logic                   alloc_ok;
  logic [3:0][PR_W-1:0]   pr_alloc;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  // A way needs a PR only if it is valid, writes a register, and the destination is not AR 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      need_in[i] = in_valid_by_way[i] & in_regwrite_by_way[i] &
                   (in_dest_AR_by_way[i] != 5'd0);
    end
  end

  assign need_cnt_in = popcnt4(need_in);
  assign need_cnt_q  = popcnt4(need_q);
  assign accept      = in_valid & in_ready;
  assign alloc_ok    = (state_q == WAIT_PR) && (fl_avail_count >= need_cnt_q) &&
                       !flush && !rst;

  // Expand the compacted free-list head onto the ways that need a PR, oldest tag first.
  always_comb begin
    logic [2:0] idx;
    // NOTE: give every always_comb target a value before any branch, so no latch is inferred.
    idx      = 3'd0;
    pr_alloc = '0;
    for (int i = 0; i < 4; i++) begin
      if (need_q[i]) begin
        pr_alloc[i] = fl_PR_by_idx[idx[1:0]];
      end
      idx = idx + {2'b0, need_q[i]};
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = (need_cnt_in == 3'd0) ? FULL : WAIT_PR;
      end
      WAIT_PR: begin
        if (alloc_ok) state_d = FULL;
      end
      FULL: begin
        if (out_ready) begin
          if (accept) state_d = (need_cnt_in == 3'd0) ? FULL : WAIT_PR;
          else        state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Handshake and free-list outputs, decoded from the current state.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    fl_deq_count = 3'd0;
    unique case (state_q)
      EMPTY:   in_ready = !flush && !rst;
      WAIT_PR: if (alloc_ok) fl_deq_count = need_cnt_q;
      FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !flush && !rst;
      end
      default: ;
    endcase
  end

  // Held bundle: captured on accept; PRs are cleared on capture and filled on allocation.
  always_ff @(posedge CLK) begin
    if (rst) begin
      need_q  <= '0;
      valid_q <= '0;
      ar_q    <= '0;
      pr_q    <= '0;
    end else if (accept) begin
      need_q  <= need_in;
      valid_q <= in_valid_by_way;
      ar_q    <= in_dest_AR_by_way;
      pr_q    <= '0;
    end else if (alloc_ok) begin
      pr_q    <= pr_alloc;
    end
  end

  assign dep_regwrite_by_way = need_q;
  assign out_regwrite_by_way = need_q;
  assign out_valid_by_way    = valid_q;
  assign out_dest_AR_by_way  = ar_q;
  assign out_dest_PR_by_way  = pr_q;

`ifdef RENAME_ALLOC_CTRL_PERF_EN
  logic [15:0] stall_q;

  // Saturating count of cycles spent waiting on the free list; flush does not clear it.
  always_ff @(posedge CLK) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == WAIT_PR) && (fl_avail_count < need_cnt_q) &&
                 (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_pr_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Self-checking bench for rename_alloc_ctrl: table-driven allocation vectors
// plus directed sequences for reset, starvation, backpressure and flush.
module tb_rename_alloc_ctrl;
  localparam int PR_W = 7;

  logic                 CLK = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_valid_by_way;
  logic [3:0]           in_regwrite_by_way;
  logic [3:0][4:0]      in_dest_AR_by_way;
  logic [3:0]           dep_regwrite_by_way;
  logic [2:0]           fl_avail_count;
  logic [3:0][PR_W-1:0] fl_PR_by_idx;
  logic [2:0]           fl_deq_count;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_valid_by_way;
  logic [3:0]           out_regwrite_by_way;
  logic [3:0][4:0]      out_dest_AR_by_way;
  logic [3:0][PR_W-1:0] out_dest_PR_by_way;
`ifdef RENAME_ALLOC_CTRL_PERF_EN
  logic [15:0]          perf_pr_stall_cycles;
`endif

  rename_alloc_ctrl #(.PR_W(PR_W)) dut (
    .CLK                 (CLK),
    .rst                 (rst),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_valid_by_way     (in_valid_by_way),
    .in_regwrite_by_way  (in_regwrite_by_way),
    .in_dest_AR_by_way   (in_dest_AR_by_way),
    .dep_regwrite_by_way (dep_regwrite_by_way),
    .fl_avail_count      (fl_avail_count),
    .fl_PR_by_idx        (fl_PR_by_idx),
    .fl_deq_count        (fl_deq_count),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_valid_by_way    (out_valid_by_way),
    .out_regwrite_by_way (out_regwrite_by_way),
    .out_dest_AR_by_way  (out_dest_AR_by_way),
    .out_dest_PR_by_way  (out_dest_PR_by_way)
`ifdef RENAME_ALLOC_CTRL_PERF_EN
    ,
    .perf_pr_stall_cycles(perf_pr_stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_bundle(input logic [3:0] v, input logic [3:0] rw, input logic [3:0][4:0] ar);
    in_valid_by_way    = v;
    in_regwrite_by_way = rw;
    in_dest_AR_by_way  = ar;
  endtask

  typedef struct {
    logic [3:0]           valid;
    logic [3:0]           rw;
    logic [3:0][4:0]      ar;
    logic [3:0][PR_W-1:0] fl;
    logic [3:0]           exp_need;
    logic [2:0]           exp_cnt;
    logic [3:0][PR_W-1:0] exp_pr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [3:0][4:0] ar_k;

    vecs[0] = '{4'b1111, 4'b1011, {5'd3, 5'd0, 5'd7, 5'd0}, {7'd40, 7'd30, 7'd20, 7'd10},
                4'b1010, 3'd2, {7'd20, 7'd0, 7'd10, 7'd0}};
    vecs[1] = '{4'b1111, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, {7'd40, 7'd30, 7'd20, 7'd10},
                4'b1111, 3'd4, {7'd40, 7'd30, 7'd20, 7'd10}};
    vecs[2] = '{4'b1000, 4'b1111, {5'd5, 5'd6, 5'd7, 5'd8}, {7'd40, 7'd30, 7'd20, 7'd10},
                4'b1000, 3'd1, {7'd10, 7'd0, 7'd0, 7'd0}};
    vecs[3] = '{4'b0101, 4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, {7'd44, 7'd33, 7'd22, 7'd11},
                4'b0101, 3'd2, {7'd0, 7'd22, 7'd0, 7'd11}};
    vecs[4] = '{4'b0000, 4'b1111, {5'd1, 5'd1, 5'd1, 5'd1}, {7'd44, 7'd33, 7'd22, 7'd11},
                4'b0000, 3'd0, {7'd0, 7'd0, 7'd0, 7'd0}};
    vecs[5] = '{4'b1111, 4'b0110, {5'd0, 5'd0, 5'd12, 5'd0}, {7'd44, 7'd33, 7'd22, 7'd11},
                4'b0010, 3'd1, {7'd0, 7'd0, 7'd11, 7'd0}};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    fl_avail_count = 3'd4; fl_PR_by_idx = {7'd4, 7'd3, 7'd2, 7'd1};
    drive_bundle(4'b1111, 4'b0000, {5'd1, 5'd2, 5'd3, 5'd4});

    // Reset held two cycles with in_valid asserted.
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fl_deq", 32'(fl_deq_count), 32'd0);
      check("rst_dep_rw", 32'(dep_regwrite_by_way), 32'd0);
      check("rst_out_pr", 32'(out_dest_PR_by_way), 32'd0);
      check("rst_out_ar", 32'(out_dest_AR_by_way), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("first_accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_ar", 32'(out_dest_AR_by_way), 32'({5'd1, 5'd2, 5'd3, 5'd4}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Table-driven allocation vectors, each starting from EMPTY.
    for (int i = 0; i < 6; i++) begin
      drive_bundle(vecs[i].valid, vecs[i].rw, vecs[i].ar);
      fl_PR_by_idx   = vecs[i].fl;
      fl_avail_count = 3'd4;
      in_valid       = 1'b1;
      #1;
      check("vec_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      #1;
      if (vecs[i].exp_cnt != 3'd0) begin
        check("vec_fl_deq", 32'(fl_deq_count), 32'(vecs[i].exp_cnt));
        check("vec_dep_rw", 32'(dep_regwrite_by_way), 32'(vecs[i].exp_need));
        check("vec_wait_out_valid", 32'(out_valid), 32'd0);
        step();
        #1;
      end
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_fl_deq_idle", 32'(fl_deq_count), 32'd0);
      check("vec_out_pr", 32'(out_dest_PR_by_way), 32'(vecs[i].exp_pr));
      check("vec_out_vbw", 32'(out_valid_by_way), 32'(vecs[i].valid));
      check("vec_out_ar", 32'(out_dest_AR_by_way), 32'(vecs[i].ar));
      check("vec_out_rw", 32'(out_regwrite_by_way), 32'(vecs[i].exp_need));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      check("vec_drained", 32'(out_valid), 32'd0);
    end

    // Starvation: need_cnt 3 with only 2 PRs for 5 cycles, then 3.
    drive_bundle(4'b1111, 4'b0111, {5'd0, 5'd1, 5'd2, 5'd3});
    fl_PR_by_idx   = {7'd99, 7'd77, 7'd66, 7'd55};
    fl_avail_count = 3'd2;
    in_valid       = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("starve_no_deq", 32'(fl_deq_count), 32'd0);
      check("starve_out_valid", 32'(out_valid), 32'd0);
      step();
    end
    fl_avail_count = 3'd3;
    #1;
    check("starve_deq3", 32'(fl_deq_count), 32'd3);
    step();
    #1;
    check("starve_deq_once", 32'(fl_deq_count), 32'd0);
    check("starve_out_valid_after", 32'(out_valid), 32'd1);
    check("starve_out_pr", 32'(out_dest_PR_by_way), 32'({7'd0, 7'd77, 7'd66, 7'd55}));
`ifdef RENAME_ALLOC_CTRL_PERF_EN
    check("perf_stall", 32'(perf_pr_stall_cycles), 32'd5);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Backpressure, then back-to-back need_cnt 0 bundles.
    ar_k = {5'd10, 5'd11, 5'd12, 5'd13};
    drive_bundle(4'b1111, 4'b0000, ar_k);
    in_valid = 1'b1;
    step();
    ar_k = {5'd20, 5'd21, 5'd22, 5'd23};
    drive_bundle(4'b1111, 4'b0000, ar_k);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_ar", 32'(out_dest_AR_by_way), 32'({5'd10, 5'd11, 5'd12, 5'd13}));
      step();
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      check("b2b_out_ar", 32'(out_dest_AR_by_way),
            32'({5'(10 * k), 5'(10 * k + 1), 5'(10 * k + 2), 5'(10 * k + 3)}));
      step();
      if (k < 3) begin
        ar_k = {5'(10 * k + 20), 5'(10 * k + 21), 5'(10 * k + 22), 5'(10 * k + 23)};
        drive_bundle(4'b1111, 4'b0000, ar_k);
      end else begin
        in_valid = 1'b0;
      end
    end
    #1;
    check("b2b_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Flush while the free list could satisfy the held bundle.
    drive_bundle(vecs[0].valid, vecs[0].rw, vecs[0].ar);
    fl_PR_by_idx   = vecs[0].fl;
    fl_avail_count = 3'd4;
    in_valid       = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check("flush_no_deq", 32'(fl_deq_count), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready_after", 32'(in_ready), 32'd1);
    check("flush_deq_after", 32'(fl_deq_count), 32'd0);

    // Flush while FULL: out_valid still shown, no accept; EMPTY next cycle.
    drive_bundle(4'b0000, 4'b0000, {5'd1, 5'd1, 5'd1, 5'd1});
    in_valid = 1'b1;
    step();
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flushfull_out_valid", 32'(out_valid), 32'd1);
    check("flushfull_in_ready", 32'(in_ready), 32'd0);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("flushfull_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
